// File: rtl/apb_master_bridge.sv
// Purpose: single-outstanding valid/ready request to APB master bridge with ACCESS-phase timeout abort.
// Latency: accept at edge N, SETUP in N+1, ACCESS from N+2, resp_valid in N+3 with zero wait states.
// Backpressure: req_ready only in IDLE (one transfer per 3 cycles max); response path has no backpressure.
module apb_master_bridge #(
   parameter int a_w       = 8,
   parameter int timeout_c = 16,   // ACCESS cycles allowed without pready; 0 disables the abort
   parameter int to_w      = 8     // must satisfy timeout_c < 2**to_w
) (
   input  logic           pclk,
   input  logic           presetn,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic           req_write,
   input  logic [a_w-1:0] req_addr,
   input  logic [31:0]    req_wdata,
   output logic           resp_valid,
   output logic [31:0]    resp_rdata,
   output logic           resp_err,
   output logic [a_w-1:0] paddr,
   output logic [31:0]    pwdata,
   output logic           pwrite,
   output logic           psel,
   output logic           penable,
   input  logic [31:0]    prdata,
   input  logic           pready
);

   typedef enum logic [1:0] {
      st_idle   = 2'd0,
      st_setup  = 2'd1,
      st_access = 2'd2
   } state_t;

   // Abort fires on the cycle where the counter reaches timeout_c-1, so ACCESS
   // never lasts longer than timeout_c cycles.
   localparam bit              to_en    = (timeout_c != 0);
   localparam logic [to_w-1:0] cnt_last = to_en ? to_w'(timeout_c - 1) : '0;

   state_t          state;
   logic [to_w-1:0] cnt;

   // Single FSM; every output is a register so nothing combinational reaches the APB bus or the core.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state      <= st_idle;
         cnt        <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         paddr      <= '0;
         pwdata     <= '0;
         pwrite     <= 1'b0;
         psel       <= 1'b0;
         penable    <= 1'b0;
      end else begin
         // Response strobe is a single-cycle pulse; data/err hold until the next response.
         resp_valid <= 1'b0;
         case (state)
            st_idle: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               if (req_valid && req_ready) begin
                  // Address/data/direction are captured once and stay frozen until the next accept.
                  paddr     <= req_addr;
                  pwdata    <= req_wdata;
                  pwrite    <= req_write;
                  psel      <= 1'b1;
                  req_ready <= 1'b0;
                  state     <= st_setup;
               end else begin
                  req_ready <= 1'b1;
               end
            end

            st_setup: begin
               penable <= 1'b1;
               cnt     <= '0;
               state   <= st_access;
            end

            st_access: begin
               if (pready) begin
                  // pready is checked first so a completion on the last timeout cycle is not an error.
                  psel       <= 1'b0;
                  penable    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= pwrite ? 32'h0 : prdata;
                  req_ready  <= 1'b1;
                  state      <= st_idle;
               end else if (to_en && (cnt == cnt_last)) begin
                  psel       <= 1'b0;
                  penable    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= 32'h0;
                  req_ready  <= 1'b1;
                  state      <= st_idle;
               end else begin
                  cnt <= cnt + to_w'(1);
               end
            end

            default: begin
               psel      <= 1'b0;
               penable   <= 1'b0;
               req_ready <= 1'b0;
               state     <= st_idle;
            end
         endcase
      end
   end

endmodule
